// File: rtl/common_pkg.sv
// ---------------------------------------------------------------------------
// common_pkg
// Shared constants and types for the FP51 core peripherals.
//
// Contents used by the interrupt arbiter:
//   NUM_OF_INT         number of interrupt sources wired to the core
//   ADDR_WIDTH         width of a code address / interrupt vector
//   INT_VECTOR_BASE    vector address of interrupt source 0
//   INT_VECTOR_STRIDE  byte spacing between consecutive interrupt vectors
//   int_arb_state_t    arbiter handshake states
//   intVectorAddr()    vector address of a given source index
// ---------------------------------------------------------------------------
package common_pkg;

    localparam int NUM_OF_INT = 7;
    localparam int ADDR_WIDTH = 16;

    localparam logic [ADDR_WIDTH-1:0] INT_VECTOR_BASE   = 16'h0003;
    localparam int                    INT_VECTOR_STRIDE = 8;

    typedef enum logic [0:0] {
        INT_ARB_IDLE,
        INT_ARB_REQ
    } int_arb_state_t;

    // The whole sum wraps at ADDR_WIDTH bits, matching the CPU's
    // program counter arithmetic.
    function automatic logic [ADDR_WIDTH-1:0] intVectorAddr(
        input logic [ADDR_WIDTH-1:0] base,
        input int                    stride,
        input int                    idx
    );
        return base + ADDR_WIDTH'(idx) * ADDR_WIDTH'(stride);
    endfunction

endpackage

// File: rtl/int_priority_enc.sv
// ---------------------------------------------------------------------------
// int_priority_enc
// Lowest-index-first priority encoder. Reports whether any request bit is
// set and, if so, the index of the lowest set bit.
//
// Ports:
//   req_i    [WIDTH-1:0]  request vector
//   found_o               at least one bit of req_i is set
//   idx_o    [IDX_W-1:0]  index of the lowest set bit (0 when none)
// ---------------------------------------------------------------------------
module int_priority_enc #(
    parameter int WIDTH = 8,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    // Scanning from the top down lets each lower set bit overwrite the
    // previous result, so the last write is the lowest index.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                found_o = 1'b1;
                idx_o   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_arbiter.sv
// ---------------------------------------------------------------------------
// interrupt_arbiter
// Two-level priority interrupt controller for the FP51 core. Latches
// peripheral request pulses, applies EA / IE mask / IP priority, and hands
// one vector at a time to the CPU over an int_gen/int_ack handshake while
// tracking which priority levels are currently in service.
//
// Ports:
//   clk         system clock
//   reset_n     synchronous active-low reset
//   int_req     one-cycle request pulses, one per source
//   ie_global   EA bit
//   ie_mask     per-source enable (IE)
//   ip_high     per-source high-priority select (IP)
//   int_ack     CPU has taken the presented vector
//   reti        one-cycle pulse when the CPU executes RETI
//   int_gen     interrupt request to the CPU
//   int_vector  vector address, stable while int_gen is high
//   pending     latched pending flags
//   in_service  bit1 = high level in service, bit0 = low level in service
// ---------------------------------------------------------------------------
module interrupt_arbiter
    import common_pkg::*;
#(
    parameter int                    NUM_OF_SOURCES = NUM_OF_INT,
    parameter logic [ADDR_WIDTH-1:0] VECTOR_BASE    = INT_VECTOR_BASE,
    parameter int                    VECTOR_STRIDE  = INT_VECTOR_STRIDE
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_OF_SOURCES-1:0] int_req,
    input  logic                      ie_global,
    input  logic [NUM_OF_SOURCES-1:0] ie_mask,
    input  logic [NUM_OF_SOURCES-1:0] ip_high,
    input  logic                      int_ack,
    input  logic                      reti,
    output logic                      int_gen,
    output logic [ADDR_WIDTH-1:0]     int_vector,
    output logic [NUM_OF_SOURCES-1:0] pending,
    output logic [1:0]                in_service
);

    localparam int IDX_W = (NUM_OF_SOURCES > 1) ? $clog2(NUM_OF_SOURCES) : 1;

    int_arb_state_t              state_q, state_d;
    logic [NUM_OF_SOURCES-1:0]   pending_q, pending_d;
    logic [1:0]                  inService_q, inService_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [ADDR_WIDTH-1:0]       vector_q, vector_d;

    logic [NUM_OF_SOURCES-1:0]   eligible;
    logic [NUM_OF_SOURCES-1:0]   hiCand;
    logic [NUM_OF_SOURCES-1:0]   loCand;
    logic                        hiFound;
    logic                        loFound;
    logic [IDX_W-1:0]            hiIdx;
    logic [IDX_W-1:0]            loIdx;
    logic [IDX_W-1:0]            winIdx;
    logic                        anyCand;
    logic                        winnerOk;
    logic                        ackTake;

    // Candidate groups. A high source may preempt anything except another
    // high handler; a low source needs both levels idle.
    always_comb begin
        eligible = pending_q & ie_mask & {NUM_OF_SOURCES{ie_global}};
        hiCand   = eligible & ip_high & {NUM_OF_SOURCES{~inService_q[1]}};
        loCand   = eligible & ~ip_high & {NUM_OF_SOURCES{inService_q == 2'b00}};
    end

    int_priority_enc #(
        .WIDTH (NUM_OF_SOURCES),
        .IDX_W (IDX_W)
    ) u_hiEnc (
        .req_i   (hiCand),
        .found_o (hiFound),
        .idx_o   (hiIdx)
    );

    int_priority_enc #(
        .WIDTH (NUM_OF_SOURCES),
        .IDX_W (IDX_W)
    ) u_loEnc (
        .req_i   (loCand),
        .found_o (loFound),
        .idx_o   (loIdx)
    );

    // The high group always beats the low group. winnerOk re-evaluates the
    // frozen winner against the current EA/IE/IP and in-service state, so a
    // priority change that removes its right to preempt also withdraws it.
    always_comb begin
        anyCand  = hiFound | loFound;
        winIdx   = hiFound ? hiIdx : loIdx;
        winnerOk = hiCand[idx_q] | loCand[idx_q];
        ackTake  = (state_q == INT_ARB_REQ) & int_ack;
    end

    // State register and all datapath registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= INT_ARB_IDLE;
            pending_q   <= '0;
            inService_q <= 2'b00;
            idx_q       <= '0;
            vector_q    <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            inService_q <= inService_d;
            idx_q       <= idx_d;
            vector_q    <= vector_d;
        end
    end

    // Next-state logic. Ack takes precedence over withdrawal.
    always_comb begin
        state_d = state_q;
        case (state_q)
            INT_ARB_IDLE: begin
                if (anyCand) begin
                    state_d = INT_ARB_REQ;
                end
            end
            INT_ARB_REQ: begin
                if (int_ack) begin
                    state_d = INT_ARB_IDLE;
                end else if (!winnerOk) begin
                    state_d = INT_ARB_IDLE;
                end
            end
            default: state_d = INT_ARB_IDLE;
        endcase
    end

    // Datapath next values. Applying the ack clear before OR-ing in new
    // requests makes a same-cycle request win. RETI works on the pre-cycle
    // in-service value and the ack set is applied afterwards, so a set of
    // the same bit wins over the clear.
    always_comb begin
        pending_d = pending_q;
        if (ackTake) begin
            pending_d[idx_q] = 1'b0;
        end
        pending_d = pending_d | int_req;

        inService_d = inService_q;
        if (reti) begin
            if (inService_q[1]) begin
                inService_d[1] = 1'b0;
            end else if (inService_q[0]) begin
                inService_d[0] = 1'b0;
            end
        end
        if (ackTake) begin
            if (ip_high[idx_q]) begin
                inService_d[1] = 1'b1;
            end else begin
                inService_d[0] = 1'b1;
            end
        end

        idx_d    = idx_q;
        vector_d = vector_q;
        if ((state_q == INT_ARB_IDLE) && anyCand) begin
            idx_d    = winIdx;
            vector_d = intVectorAddr(VECTOR_BASE, VECTOR_STRIDE, int'(winIdx));
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        int_gen    = (state_q == INT_ARB_REQ);
        int_vector = vector_q;
        pending    = pending_q;
        in_service = inService_q;
    end

endmodule

// File: tb/tb_interrupt_arbiter.sv
// ---------------------------------------------------------------------------
// tb_interrupt_arbiter
// Directed self-checking bench for interrupt_arbiter. Expected vectors are
// queued when a request is driven and popped when the DUT raises int_gen.
// ---------------------------------------------------------------------------
module tb_interrupt_arbiter;

    localparam int N = 7;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [N-1:0]  int_req;
    logic          ie_global;
    logic [N-1:0]  ie_mask;
    logic [N-1:0]  ip_high;
    logic          int_ack;
    logic          reti;
    logic          int_gen;
    logic [15:0]   int_vector;
    logic [N-1:0]  pending;
    logic [1:0]    in_service;

    int            total = 0;
    int            bad   = 0;
    logic [15:0]   expQ[$];

    interrupt_arbiter dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .int_req    (int_req),
        .ie_global  (ie_global),
        .ie_mask    (ie_mask),
        .ip_high    (ip_high),
        .int_ack    (int_ack),
        .reti       (reti),
        .int_gen    (int_gen),
        .int_vector (int_vector),
        .pending    (pending),
        .in_service (in_service)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive the pulse inputs for exactly one edge.
    task automatic applyStimulus(input logic [N-1:0] req, input logic ack, input logic rt);
        int_req = req;
        int_ack = ack;
        reti    = rt;
        step();
        int_req = '0;
        int_ack = 1'b0;
        reti    = 1'b0;
    endtask

    // Wait up to maxCycles edges for int_gen, then compare the vector with
    // the oldest queued expectation.
    task automatic waitGrant(input string tag, input int maxCycles);
        logic [15:0] expVec;
        int          cnt;
        cnt = 0;
        while (int_gen !== 1'b1 && cnt < maxCycles) begin
            step();
            cnt++;
        end
        checkOutput({tag, "_gen"}, 32'(int_gen), 32'd1);
        total++;
        assert (expQ.size() > 0)
        else begin
            bad++;
            $error("[TB] FAIL %s_sbEmpty observed=grant expected=none", tag);
        end
        if (expQ.size() > 0) begin
            expVec = expQ.pop_front();
            checkOutput({tag, "_vec"}, 32'(int_vector), 32'(expVec));
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        int_req   = '0;
        ie_global = 1'b0;
        ie_mask   = '0;
        ip_high   = '0;
        int_ack   = 1'b0;
        reti      = 1'b0;

        // Reset held with toggling requests.
        ie_global = 1'b1;
        ie_mask   = '1;
        for (int i = 0; i < 4; i++) begin
            int_req = N'($urandom);
            step();
            checkOutput("rst_gen", 32'(int_gen), 32'd0);
            checkOutput("rst_pend", 32'(pending), 32'd0);
        end
        checkOutput("rst_isv", 32'(in_service), 32'd0);
        checkOutput("rst_vec", 32'(int_vector), 32'd0);
        int_req = '0;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("postrst_gen", 32'(int_gen), 32'd0);
        end

        // Single low request on idx1, exact latency.
        expQ.push_back(16'h000B);
        applyStimulus(7'b0000010, 1'b0, 1'b0);
        checkOutput("s_pend", 32'(pending), 32'h02);
        checkOutput("s_gen0", 32'(int_gen), 32'd0);
        step();
        waitGrant("single", 0);
        applyStimulus('0, 1'b1, 1'b0);
        checkOutput("s_ackpend", 32'(pending), 32'h00);
        checkOutput("s_ackisv", 32'(in_service), 32'd1);
        checkOutput("s_ackgen", 32'(int_gen), 32'd0);
        applyStimulus('0, 1'b0, 1'b1);
        checkOutput("s_reti", 32'(in_service), 32'd0);

        // Simultaneous idx0 (low) and idx3 (high).
        ip_high = 7'b0001000;
        expQ.push_back(16'h001B);
        expQ.push_back(16'h0003);
        applyStimulus(7'b0001001, 1'b0, 1'b0);
        step();
        waitGrant("simHi", 0);
        applyStimulus('0, 1'b1, 1'b0);
        checkOutput("sim_isv", 32'(in_service), 32'd2);
        checkOutput("sim_pend", 32'(pending), 32'h01);
        step();
        step();
        checkOutput("sim_blocked", 32'(int_gen), 32'd0);
        applyStimulus('0, 1'b0, 1'b1);
        waitGrant("simLo", 2);
        applyStimulus('0, 1'b1, 1'b0);
        checkOutput("sim_isv2", 32'(in_service), 32'd1);
        applyStimulus('0, 1'b0, 1'b1);

        // Nesting: low idx2, preempted by high idx4, then low idx5 blocked.
        ip_high = 7'b0010000;
        expQ.push_back(16'h0013);
        applyStimulus(7'b0000100, 1'b0, 1'b0);
        step();
        waitGrant("nestLo", 0);
        applyStimulus('0, 1'b1, 1'b0);
        expQ.push_back(16'h0023);
        applyStimulus(7'b0010000, 1'b0, 1'b0);
        step();
        waitGrant("nestHi", 0);
        applyStimulus('0, 1'b1, 1'b0);
        checkOutput("nest_isv", 32'(in_service), 32'd3);
        expQ.push_back(16'h002B);
        applyStimulus(7'b0100000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("nest_blk11", 32'(int_gen), 32'd0);
        end
        applyStimulus('0, 1'b0, 1'b1);
        checkOutput("nest_reti1", 32'(in_service), 32'd1);
        step();
        step();
        checkOutput("nest_blk01", 32'(int_gen), 32'd0);
        applyStimulus('0, 1'b0, 1'b1);
        checkOutput("nest_reti2", 32'(in_service), 32'd0);
        waitGrant("nestIdx5", 3);
        applyStimulus('0, 1'b1, 1'b0);
        applyStimulus('0, 1'b0, 1'b1);

        // Withdrawal of idx6 when EA drops.
        expQ.push_back(16'h0033);
        applyStimulus(7'b1000000, 1'b0, 1'b0);
        step();
        waitGrant("wd", 0);
        ie_global = 1'b0;
        step();
        checkOutput("wd_gen", 32'(int_gen), 32'd0);
        checkOutput("wd_pend", 32'(pending), 32'h40);
        ie_global = 1'b1;
        expQ.push_back(16'h0033);
        waitGrant("wdAgain", 2);
        applyStimulus('0, 1'b1, 1'b0);
        applyStimulus('0, 1'b0, 1'b1);

        // Same-cycle ack and request on idx0.
        expQ.push_back(16'h0003);
        applyStimulus(7'b0000001, 1'b0, 1'b0);
        step();
        waitGrant("ackReq", 0);
        applyStimulus(7'b0000001, 1'b1, 1'b0);
        checkOutput("ar_pend", 32'(pending), 32'h01);
        checkOutput("ar_isv", 32'(in_service), 32'd1);
        step();
        checkOutput("ar_blk", 32'(int_gen), 32'd0);
        expQ.push_back(16'h0003);
        applyStimulus('0, 1'b0, 1'b1);
        waitGrant("ackReqAgain", 2);
        applyStimulus('0, 1'b1, 1'b0);

        // High idx4 preempts low level; ack and reti in the same cycle.
        expQ.push_back(16'h0023);
        applyStimulus(7'b0010000, 1'b0, 1'b0);
        step();
        waitGrant("ackReti", 0);
        applyStimulus('0, 1'b1, 1'b1);
        checkOutput("ackReti_isv", 32'(in_service), 32'd2);
        applyStimulus('0, 1'b0, 1'b1);
        checkOutput("ackReti_clr", 32'(in_service), 32'd0);

        // Ack outside REQ is ignored.
        applyStimulus('0, 1'b1, 1'b0);
        checkOutput("idleAck", 32'(in_service), 32'd0);

        // Masked source stays pending until unmasked.
        ie_mask = 7'b1110111;
        applyStimulus(7'b0001000, 1'b0, 1'b0);
        step();
        step();
        checkOutput("mask_gen", 32'(int_gen), 32'd0);
        checkOutput("mask_pend", 32'(pending), 32'h08);
        ie_mask = '1;
        expQ.push_back(16'h001B);
        waitGrant("unmask", 2);
        applyStimulus('0, 1'b1, 1'b0);
        checkOutput("unmask_isv", 32'(in_service), 32'd1);
        applyStimulus('0, 1'b0, 1'b1);

        // Reset in the middle of a handshake.
        expQ.push_back(16'h000B);
        applyStimulus(7'b0000010, 1'b0, 1'b0);
        step();
        waitGrant("midRst", 0);
        reset_n = 1'b0;
        applyStimulus(7'b0100100, 1'b1, 1'b0);
        reset_n = 1'b1;
        checkOutput("mr_gen", 32'(int_gen), 32'd0);
        checkOutput("mr_pend", 32'(pending), 32'd0);
        checkOutput("mr_isv", 32'(in_service), 32'd0);
        checkOutput("mr_vec", 32'(int_vector), 32'd0);
        step();
        step();
        checkOutput("mr_idle", 32'(int_gen), 32'd0);

        checkOutput("sb_left", 32'(expQ.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/interrupt_arbiter.md
# interrupt_arbiter

Two-level priority interrupt controller for the FP51 core. It latches request pulses from the `NUM_OF_INT` peripheral sources (INT0/1, timers, UART, ADC, codec) and applies the global enable, per-source mask and priority bits. It then presents one vector at a time to the CPU with a request/acknowledge handshake, tracking in-service levels so that only high priority can preempt low. It sits between the peripheral interrupt outputs and the CPU core's interrupt entry logic; the IE/IP SFRs drive its enable inputs.

## Interface
- `NUM_OF_SOURCES`, default `NUM_OF_INT` (7): number of interrupt sources; index 0 is the highest natural priority.
- `VECTOR_BASE`, default 16'h0003: vector address of source 0.
- `VECTOR_STRIDE`, default 8: byte spacing between consecutive vectors.
- `clk`  in  1  system clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `int_req`  in  `NUM_OF_SOURCES`  one-cycle request pulses from the peripherals.
- `ie_global`  in  1  EA bit.
- `ie_mask`  in  `NUM_OF_SOURCES`  per-source enable.
- `ip_high`  in  `NUM_OF_SOURCES`  1 = high priority level.
- `int_ack`  in  1  CPU has taken the presented vector.
- `reti`  in  1  one-cycle pulse when the CPU executes RETI.
- `int_gen`  out  1  interrupt request to the CPU.
- `int_vector`  out  `ADDR_WIDTH` (16)  vector address; stable while `int_gen`=1.
- `pending`  out  `NUM_OF_SOURCES`  latched pending flags.
- `in_service`  out  2  bit1 = high level in service, bit0 = low level in service.

## Operation
- **Pending register:**
  - `int_req[i]` sets `pending[i]`.
  - `int_ack` in REQ clears the pending bit of the selected index.
  - If a set and a clear hit the same bit in the same cycle, set wins.
- **Eligibility:** `elig = pending & ie_mask & {N{ie_global}}`.
  - High candidates: `elig & ip_high`. Eligible only if `in_service[1]`=0.
  - Low candidates: `elig & ~ip_high`. Eligible only if `in_service`=2'b00.
  - The high group always beats the low group. Within a group, the lowest index wins.
- **FSM states:**
  - IDLE: if any eligible source exists, register the winner index and vector, go to REQ.
  - REQ: `int_gen`=1. Index and vector are frozen.
    - On `int_ack`: clear the pending bit, set the `in_service` bit for the winner's level, go to IDLE.
    - Else, if the winner is no longer eligible (EA cleared, masked, or priority changed so that it can no longer preempt): withdraw and go to IDLE. Pending is retained.
    - `int_ack` has precedence over withdrawal in the same cycle.
- **Vector:** `VECTOR_BASE + idx*VECTOR_STRIDE`, computed with `ADDR_WIDTH` arithmetic. Defaults give 0x0003, 0x000B, 0x0013, 0x001B, 0x0023, 0x002B, 0x0033.
- **reti:**
  - Clears `in_service[1]` if set, else `in_service[0]`.
  - Ignored when `in_service`=0.
  - `reti` and `int_ack` in the same cycle: `reti` is evaluated on the pre-cycle `in_service`, then the ack sets its bit. If both target the same bit, set wins.
- `int_ack` outside REQ is ignored.

## Timing
- **Reset** (`reset_n`=0 at a rising edge): state IDLE, `pending`=0, `in_service`=0, `int_gen`=0, `int_vector`=16'h0000. This takes effect mid-handshake too; no ack is remembered.
- **Request latency:** pulse at edge N → `pending` visible after N+1 → `int_gen`=1 with a valid vector after N+2.
- **After ack:** `int_gen` drops on the next cycle. IDLE lasts at least one cycle, so the next `int_gen` is no earlier than 2 cycles after the ack.
- **Withdrawal:** `int_gen` drops one cycle after the condition is seen.
- **Outputs:** all outputs are registered; no combinational path from inputs to `int_gen`/`int_vector`.

## Structure
- **common_pkg additions:** `INT_VECTOR_BASE` (16'h0003) and `INT_VECTOR_STRIDE` (8), which feed the parameter defaults. Also a typedef enum `int_arb_state_t {INT_ARB_IDLE, INT_ARB_REQ}`.
- **One sub-module:** `int_priority_enc`, a parameterised lowest-index-first encoder (input vector → `found`, index). It is instantiated twice, once for the high group and once for the low group.

## Test plan
1. **Reset:** hold `reset_n`=0 with requests toggling → all outputs 0. Release → no `int_gen` until a new pulse arrives.
2. **Single request:** EA=1, all masks set, pulse `int_req[1]` at cycle 0 → `int_gen`=1 with vector 0x000B at cycle 2. Ack → `pending[1]`=0, `in_service`=01, `int_gen`=0 the next cycle.
3. **Simultaneous requests:** pulse idx 0 and idx 3 together with `ip_high[3]`=1 → vector 0x001B first. After ack → `in_service`=10. After `reti` → vector 0x0003 is presented.
4. **Nesting and blocking:**
   - idx2 (low) in service, pulse idx4 (high) → preempts with vector 0x0023.
   - Then pulse idx5 (low) → no `int_gen` until two `reti` pulses clear `in_service` to 00, then vector 0x002B.
5. **Withdrawal:** in REQ for idx6, clear `ie_global` → `int_gen`=0 the next cycle, `pending[6]` stays 1. Restore EA → vector 0x0033 is presented again within 2 cycles.
6. **Same-cycle ack and request:** assert `int_ack` and `int_req[0]` in the same cycle → `pending[0]` stays 1, `in_service` updates. After `reti`, idx0 is presented again.
